// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-lite slave that serves master transfers from a single-port synchronous
//   SRAM. Reads and writes complete with zero wait states. Write data is
//   parked in a one-entry buffer and written to the SRAM in a later cycle that
//   has no read, and reads of a parked word are forwarded from the buffer.
//   Out-of-window, misaligned and oversize transfers get a two-cycle ERROR.
//
//   Optional feature macro: AHB_SRAM_PARITY_EN
//     When defined, the SRAM word is 36 bits and bits[35:32] hold the even
//     parity of each byte. A parity mismatch on a lane read from the SRAM
//     (not forwarded) turns the read data phase into a two-cycle ERROR.
//
// Ports
//   aclk, aresetn            clock (rising edge), async active-low reset
//   s_hsel .. s_hready       AHB-lite address/data phase inputs
//   s_hready_resp            HREADYOUT
//   s_hresp                  bit0 = ERROR, bit1 tied 0
//   s_hrdata                 read data, zero outside read data phases
//   sram_ce_n/we_n/bwe_n     SRAM strobes, active low
//   sram_addr/wdata/q        SRAM word address, write data, read data (1-cycle)
module ahb_sram_slave #(
   parameter int          ADDR_WIDTH = 13,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
`ifdef AHB_SRAM_PARITY_EN
   localparam int         SRAM_DW    = 36
`else
   localparam int         SRAM_DW    = 32
`endif
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  s_hsel,
   input  logic [31:0]           s_haddr,
   input  logic [1:0]            s_htrans,
   input  logic                  s_hwrite,
   input  logic [2:0]            s_hsize,
   input  logic [2:0]            s_hburst,
   input  logic [31:0]           s_hwdata,
   input  logic                  s_hready,
   output logic                  s_hready_resp,
   output logic [1:0]            s_hresp,
   output logic [31:0]           s_hrdata,
   output logic                  sram_ce_n,
   output logic                  sram_we_n,
   output logic [3:0]            sram_bwe_n,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [SRAM_DW-1:0]    sram_wdata,
   input  logic [SRAM_DW-1:0]    sram_q
);

   typedef enum logic [2:0] {S_IDLE, S_RDATA, S_WDATA, S_WWAIT, S_ERR1, S_ERR2} state_t;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr, r_buf_addr;
   logic [3:0]            r_wr_mask, r_buf_mask;
   logic [31:0]           r_buf_data;
   logic                  r_buf_vld;

   logic                  w_sel, w_err, w_hazard, w_perr, w_hready, w_herr;
   logic                  w_accept, w_rd_acc, w_wr_acc, w_load, w_drain, w_fwd;
   logic [3:0]            w_lanes, w_fwd_mask;
   logic [31:0]           w_rdata_mrg, w_wdata_msk;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [SRAM_DW-1:0]    w_sram_wd;
   logic                  w_unused;

   assign w_unused = ^{s_htrans[0], s_hburst};
   assign w_addr   = s_haddr[ADDR_WIDTH+1:2];
   // Gating with aresetn keeps every output at its reset value while reset
   // is held, even if the master keeps presenting a transfer.
   assign w_sel    = aresetn & s_hsel & s_htrans[1];

   always_comb begin
      w_err = (s_haddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) | s_hsize[2] |
              (s_hsize == 3'd3) |
              ((s_hsize == 3'd1) & s_haddr[0]) |
              ((s_hsize == 3'd2) & (s_haddr[1:0] != 2'b00));
      case (s_hsize[1:0])
         2'd0:    w_lanes = 4'b0001 << s_haddr[1:0];
         2'd1:    w_lanes = s_haddr[1] ? 4'b1100 : 4'b0011;
         default: w_lanes = 4'b1111;
      endcase
   end

   // A read address phase next to a write data phase, with the buffer still
   // occupied, leaves no cycle to drain. s_hready is deliberately not used
   // here: during our own data phase it is our own HREADYOUT.
   assign w_hazard   = (r_state == S_WDATA) & r_buf_vld & w_sel & ~s_hwrite & ~w_err;

   assign w_fwd      = r_buf_vld & (r_buf_addr == r_rd_addr);
   assign w_fwd_mask = w_fwd ? r_buf_mask : 4'b0000;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_rdata_mrg[8*i +: 8] = w_fwd_mask[i] ? r_buf_data[8*i +: 8] : sram_q[8*i +: 8];
      assign w_wdata_msk[8*i +: 8] = r_wr_mask[i]  ? s_hwdata[8*i +: 8]   : 8'h00;
   end

`ifdef AHB_SRAM_PARITY_EN
   logic [3:0] w_par_bad, w_par_wr;
   for (genvar i = 0; i < 4; i++) begin : g_par
      assign w_par_wr[i]  = ^r_buf_data[8*i +: 8];
      // forwarded lanes never came from the SRAM, so they are not checked
      assign w_par_bad[i] = ~w_fwd_mask[i] & (sram_q[32+i] != ^sram_q[8*i +: 8]);
   end
   assign w_perr    = (r_state == S_RDATA) & (|w_par_bad);
   assign w_sram_wd = {w_par_wr, r_buf_data};
`else
   assign w_perr    = 1'b0;
   assign w_sram_wd = r_buf_data;
`endif

   // response outputs depend only on state and the address-phase inputs
   always_comb begin
      w_hready = 1'b1;
      w_herr   = 1'b0;
      case (r_state)
         S_RDATA: if (w_perr) begin w_hready = 1'b0; w_herr = 1'b1; end
         S_WDATA: if (w_hazard) w_hready = 1'b0;
         S_ERR1:  begin w_hready = 1'b0; w_herr = 1'b1; end
         S_ERR2:  w_herr = 1'b1;
         default: ;
      endcase
   end

   assign w_accept = w_sel & s_hready & w_hready;
   assign w_rd_acc = w_accept & ~s_hwrite & ~w_err;
   assign w_wr_acc = w_accept & s_hwrite & ~w_err;
   assign w_load   = ((r_state == S_WDATA) & ~w_hazard) | (r_state == S_WWAIT);
   assign w_drain  = r_buf_vld & ~w_rd_acc;

   always_comb begin
      w_next = r_state;
      if (!w_hready)     w_next = (r_state == S_WDATA) ? S_WWAIT : S_ERR2;
      else if (w_accept) w_next = w_err ? S_ERR1 : (s_hwrite ? S_WDATA : S_RDATA);
      else               w_next = S_IDLE;
   end

   always_comb begin
      sram_ce_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_bwe_n = 4'hF;
      sram_addr  = '0;
      sram_wdata = '0;
      if (w_rd_acc) begin
         sram_ce_n = 1'b0;
         sram_addr = w_addr;
      end else if (w_drain) begin
         sram_ce_n  = 1'b0;
         sram_we_n  = 1'b0;
         sram_bwe_n = ~r_buf_mask;
         sram_addr  = r_buf_addr;
         sram_wdata = w_sram_wd;
      end
   end

   assign s_hready_resp = w_hready;
   assign s_hresp       = {1'b0, w_herr};
   assign s_hrdata      = ((r_state == S_RDATA) && !w_perr) ? w_rdata_mrg : 32'h0;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= S_IDLE;
         r_rd_addr  <= '0;
         r_wr_addr  <= '0;
         r_wr_mask  <= '0;
         r_buf_vld  <= 1'b0;
         r_buf_addr <= '0;
         r_buf_data <= '0;
         r_buf_mask <= '0;
      end else begin
         r_state <= w_next;
         if (w_rd_acc) r_rd_addr <= w_addr;
         if (w_wr_acc) begin
            r_wr_addr <= w_addr;
            r_wr_mask <= w_lanes;
         end
         // load wins over drain: the old entry is on the SRAM pins this cycle
         if (w_load) begin
            r_buf_vld  <= 1'b1;
            r_buf_addr <= r_wr_addr;
            r_buf_data <= w_wdata_msk;
            r_buf_mask <= r_wr_mask;
         end else if (w_drain) begin
            r_buf_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
   localparam int AW = 13;
`ifdef AHB_SRAM_PARITY_EN
   localparam int SDW = 36;
`else
   localparam int SDW = 32;
`endif

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic           s_hsel, s_hwrite, s_hready, s_hready_resp;
   logic [31:0]    s_haddr, s_hwdata, s_hrdata;
   logic [1:0]     s_htrans, s_hresp;
   logic [2:0]     s_hsize;
   logic           sram_ce_n, sram_we_n;
   logic [3:0]     sram_bwe_n;
   logic [AW-1:0]  sram_addr;
   logic [SDW-1:0] sram_wdata, sram_q, r_q;
   logic [SDW-1:0] mem [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;
   assign s_hready = s_hready_resp;

   ahb_sram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_hsel(s_hsel), .s_haddr(s_haddr),
      .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(3'd0),
      .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hready_resp(s_hready_resp),
      .s_hresp(s_hresp), .s_hrdata(s_hrdata), .sram_ce_n(sram_ce_n),
      .sram_we_n(sram_we_n), .sram_bwe_n(sram_bwe_n), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_q(sram_q));

   // SRAM model: byte-masked write, registered read
   always @(posedge aclk) begin
      if (!sram_ce_n) begin
         if (!sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
               if (!sram_bwe_n[b]) begin
                  mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
`ifdef AHB_SRAM_PARITY_EN
                  mem[sram_addr][32+b] <= sram_wdata[32+b];
`endif
               end
            end
         end else begin
            r_q <= mem[sram_addr];
         end
      end
   end

`ifdef AHB_SRAM_PARITY_EN
   logic par_flip = 1'b0;
   assign sram_q = par_flip ? (r_q ^ 36'h2_0000_0000) : r_q;
`else
   assign sram_q = r_q;
`endif

   function automatic logic [SDW-1:0] mk(input logic [31:0] d);
`ifdef AHB_SRAM_PARITY_EN
      return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0], d};
`else
      return d;
`endif
   endfunction

   typedef struct {
      logic sel; logic [1:0] tr; logic wr; logic [2:0] sz; logic [31:0] a; logic [31:0] wd;
      logic rdy; logic [1:0] rsp; logic [31:0] rd;
      logic ce; logic we; logic [3:0] bwe; logic [AW-1:0] sa; logic [31:0] swd;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic rdy, input logic [1:0] rsp,
                      input logic [31:0] rd, input logic ce, input logic we, input logic [3:0] bwe,
                      input logic [AW-1:0] sa, input logic [31:0] swd);
      vec_t v;
      v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
      v.rdy = rdy; v.rsp = rsp; v.rd = rd; v.ce = ce; v.we = we; v.bwe = bwe; v.sa = sa; v.swd = swd;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic drv(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
      s_hsel = sel; s_htrans = tr; s_hwrite = wr; s_hsize = sz; s_haddr = a; s_hwdata = wd;
   endtask

   task automatic chk_reset_vals(input int row);
      chk("rst_hready", row, 32'(s_hready_resp), 32'h1);
      chk("rst_hresp",  row, 32'(s_hresp), 32'h0);
      chk("rst_hrdata", row, s_hrdata, 32'h0);
      chk("rst_ce_n",   row, 32'(sram_ce_n), 32'h1);
      chk("rst_we_n",   row, 32'(sram_we_n), 32'h1);
      chk("rst_bwe_n",  row, 32'(sram_bwe_n), 32'hF);
      chk("rst_addr",   row, 32'(sram_addr), 32'h0);
      chk("rst_wdata",  row, sram_wdata[31:0], 32'h0);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < (1<<AW); i++) mem[i] = mk(32'h0);
      mem[2]    = mk(32'hCAFEF00D);
      mem[4]    = mk(32'h55555555);
      mem[8]    = mk(32'h11223344);
      mem[8191] = mk(32'h0BADCAFE);
      r_q = '0;
      drv(0, 2'd0, 0, 3'd0, 32'h0, 32'h0);

      //   sel tr    wr sz    addr         hwdata        rdy rsp   hrdata        ce we bwe   saddr     swd
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 0
      add(1, 2'd2, 1, 3'd2, 32'h10,      32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 1 W 0x10
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'hDEADBEEF, 1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 2 load
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h0,        0, 0, 4'h0, 13'h4,    32'hDEADBEEF); // 3 drain
      add(1, 2'd2, 0, 3'd2, 32'h10,      32'h0,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'h4,    32'h0);        // 4 R 0x10
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'hDEADBEEF, 1, 1, 4'hF, 13'h0,    32'h0);        // 5
      add(1, 2'd2, 1, 3'd0, 32'h21,      32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 6 W byte 0x21
      add(1, 2'd2, 0, 3'd2, 32'h20,      32'hFFFFAAFF, 1, 2'd0, 32'h0,        0, 1, 4'hF, 13'h8,    32'h0);        // 7 R 0x20
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h1122AA44, 0, 0, 4'hD, 13'h8,    32'h0000AA00); // 8 fwd + drain
      add(1, 2'd2, 0, 3'd2, 32'h20,      32'h0,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'h8,    32'h0);        // 9
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h1122AA44, 1, 1, 4'hF, 13'h0,    32'h0);        // 10
      add(1, 2'd2, 1, 3'd2, 32'h0,       32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 11 W 0x0
      add(1, 2'd2, 1, 3'd2, 32'h4,       32'h1,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 12 W 0x4
      add(1, 2'd2, 0, 3'd2, 32'h8,       32'h2,        0, 2'd0, 32'h0,        0, 0, 4'h0, 13'h0,    32'h1);        // 13 hazard wait
      add(1, 2'd2, 0, 3'd2, 32'h8,       32'h2,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'h2,    32'h0);        // 14 R 0x8 taken
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'hCAFEF00D, 0, 0, 4'h0, 13'h1,    32'h2);        // 15
      add(1, 2'd2, 0, 3'd2, 32'h8000,    32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 16 out of range
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        0, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 17 ERR1
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 18 ERR2
      add(1, 2'd2, 1, 3'd1, 32'h41,      32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 19 odd half
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        0, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 20
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 21
      add(1, 2'd2, 1, 3'd2, 32'h30,      32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 22 W 0x30
      add(1, 2'd2, 0, 3'd3, 32'h0,       32'h12345678, 1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 23 size 3
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        0, 2'd1, 32'h0,        0, 0, 4'h0, 13'hC,    32'h12345678); // 24 ERR1 + drain
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 25
      add(1, 2'd2, 0, 3'd2, 32'h30,      32'h0,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'hC,    32'h0);        // 26
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h12345678, 1, 1, 4'hF, 13'h0,    32'h0);        // 27
      add(1, 2'd2, 0, 3'd2, 32'h2,       32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 28 misaligned word
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        0, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 29
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd1, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 30
      add(1, 2'd1, 0, 3'd2, 32'h8,       32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 31 BUSY
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 32
      add(1, 2'd2, 0, 3'd2, 32'h7FFC,    32'h0,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'h1FFF, 32'h0);        // 33 top word
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h0BADCAFE, 1, 1, 4'hF, 13'h0,    32'h0);        // 34
      add(1, 2'd2, 1, 3'd2, 32'h50,      32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 35
      add(1, 2'd2, 1, 3'd2, 32'h54,      32'h50505050, 1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 36
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h54545454, 1, 2'd0, 32'h0,        0, 0, 4'h0, 13'd20,   32'h50505050); // 37 drain+load
      add(1, 2'd2, 0, 3'd2, 32'h54,      32'h0,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'd21,   32'h0);        // 38
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h54545454, 0, 0, 4'h0, 13'd21,   32'h54545454); // 39
      add(1, 2'd2, 0, 3'd2, 32'h50,      32'h0,        1, 2'd0, 32'h0,        0, 1, 4'hF, 13'd20,   32'h0);        // 40
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h50505050, 1, 1, 4'hF, 13'h0,    32'h0);        // 41
      add(1, 2'd2, 1, 3'd1, 32'h42,      32'h0,        1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 42 W half 0x42
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'hBEEF1234, 1, 2'd0, 32'h0,        1, 1, 4'hF, 13'h0,    32'h0);        // 43
      add(0, 2'd0, 0, 3'd0, 32'h0,       32'h0,        1, 2'd0, 32'h0,        0, 0, 4'h3, 13'd16,   32'hBEEF0000); // 44

      // reset state
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk_reset_vals(-1);
      aresetn = 1'b1;

      foreach (tv[i]) begin
         v = tv[i];
         @(posedge aclk); #1;
         drv(v.sel, v.tr, v.wr, v.sz, v.a, v.wd);
         @(negedge aclk);
         chk("hready_resp", i, 32'(s_hready_resp), 32'(v.rdy));
         chk("hresp",       i, 32'(s_hresp), 32'(v.rsp));
         chk("hrdata",      i, s_hrdata, v.rd);
         chk("sram_ce_n",   i, 32'(sram_ce_n), 32'(v.ce));
         if (!v.ce) begin
            chk("sram_we_n", i, 32'(sram_we_n), 32'(v.we));
            chk("sram_addr", i, 32'(sram_addr), 32'(v.sa));
            if (!v.we) begin
               chk("sram_bwe_n",  i, 32'(sram_bwe_n), 32'(v.bwe));
               chk("sram_wdata",  i, sram_wdata[31:0], v.swd);
            end
         end
      end

      // reset with a buffered write pending: the entry must be discarded
      @(posedge aclk); #1; drv(1, 2'd2, 1, 3'd2, 32'h10, 32'h0);
      @(posedge aclk); #1; drv(1, 2'd2, 0, 3'd2, 32'h10, 32'h99999999);
      @(posedge aclk); #1; drv(1, 2'd2, 0, 3'd2, 32'h8, 32'h0);
      @(negedge aclk);
      chk("rst_seq_fwd",  100, s_hrdata, 32'h99999999);
      chk("rst_seq_ce_n", 100, 32'(sram_ce_n), 32'h0);
      chk("rst_seq_we_n", 100, 32'(sram_we_n), 32'h1);
      @(posedge aclk); #1; aresetn = 1'b0; #1;
      chk_reset_vals(101);
      @(negedge aclk); aresetn = 1'b1;
      @(posedge aclk); #1; drv(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
      @(negedge aclk);
      chk("rst_seq_rd_ce",   102, 32'(sram_ce_n), 32'h0);
      chk("rst_seq_rd_addr", 102, 32'(sram_addr), 32'h4);
      @(posedge aclk); #1; drv(0, 2'd0, 0, 3'd0, 32'h0, 32'h0);
      @(negedge aclk);
      chk("rst_seq_old_data", 103, s_hrdata, 32'hDEADBEEF);
      chk("rst_seq_no_drain", 103, 32'(sram_ce_n), 32'h1);

`ifdef AHB_SRAM_PARITY_EN
      // parity fault on a non-buffered word
      @(posedge aclk); #1; drv(1, 2'd2, 0, 3'd2, 32'h20, 32'h0); par_flip = 1'b1;
      @(posedge aclk); #1; drv(0, 2'd0, 0, 3'd0, 32'h0, 32'h0);
      @(negedge aclk);
      chk("par_err1_rdy",  110, 32'(s_hready_resp), 32'h0);
      chk("par_err1_resp", 110, 32'(s_hresp), 32'h1);
      chk("par_err1_data", 110, s_hrdata, 32'h0);
      @(posedge aclk); #1; par_flip = 1'b0;
      @(negedge aclk);
      chk("par_err2_rdy",  111, 32'(s_hready_resp), 32'h1);
      chk("par_err2_resp", 111, 32'(s_hresp), 32'h1);
`endif

      @(posedge aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-lite slave responder that serves AHB master transfers from a single-port synchronous SRAM.
- Example master: the USB controller DMA port, for local packet buffering without the AXI fabric.
- Zero-wait-state reads and writes, using a one-entry deferred write buffer with read forwarding.
- Out-of-range, misaligned and oversize transfers get a two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 13: SRAM word-address bits; depth is 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte base of the window; must be aligned to 2^(ADDR_WIDTH+2).

Ports:
- aclk  in  1  clock, all logic rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_hsel  in  1  slave select.
- s_haddr  in  32  byte address.
- s_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- s_hwrite  in  1  1 = write.
- s_hsize  in  3  0 = byte, 1 = half, 2 = word; others error.
- s_hburst  in  3  ignored (each beat handled independently).
- s_hwdata  in  32  write data, data phase.
- s_hready  in  1  bus HREADY.
- s_hready_resp  out  1  slave HREADYOUT.
- s_hresp  out  2  bit0 = ERROR, bit1 always 0.
- s_hrdata  out  32  read data.
- sram_ce_n  out  1  chip enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_bwe_n  out  4  byte write enable, active low.
- sram_addr  out  ADDR_WIDTH  word address.
- sram_wdata  out  32 (36 with parity)  write data.
- sram_q  in  32 (36 with parity)  read data, 1-cycle latency after ce_n low with we_n high.

Behaviour:
- Reset values: s_hready_resp=1, s_hresp=0, s_hrdata=0, sram_ce_n=1, sram_we_n=1, sram_bwe_n=4'hF, sram_addr=0, sram_wdata=0. Write buffer invalid, FSM in IDLE.
- Reset mid-transfer: a pending buffered write is discarded.
- Accept: address phase taken when s_hsel & s_htrans[1] & s_hready. BUSY and IDLE give OKAY with no SRAM access.
- Error check at accept, error if any of:
  - s_haddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];
  - s_hsize>2;
  - s_hsize=1 with haddr[0]=1;
  - s_hsize=2 with haddr[1:0]!=0.
- Error response: cycle 1 s_hready_resp=0, s_hresp=01; cycle 2 s_hready_resp=1, s_hresp=01. No SRAM access, buffer untouched. Address phases during cycle 1 are ignored.
- Byte lanes are little-endian: byte uses lane haddr[1:0], half uses lanes {haddr[1],x}, word uses all 4.
- Read: SRAM read issued combinationally in the accepted address phase (ce_n=0, we_n=1, addr=haddr word index).
  - s_hrdata is valid in the next cycle (data phase), zero wait states.
  - s_hrdata=0 outside read data phases.
- Write buffer holds one entry: addr, 32-bit data, 4-bit byte mask, valid.
  - Loaded at the end of a write data phase (s_hready_resp=1), from s_hwdata masked by the captured lanes.
- Drain: a valid entry is written (ce_n=0, we_n=0, bwe_n=~mask) in any cycle where no read address phase is accepted. valid clears that edge.
  - Drain and load in the same cycle are legal: the old entry is written and the new one loaded.
- Forwarding: if a read's word address equals a valid (undrained) entry's address, s_hrdata takes buffered bytes on masked lanes and sram_q on the rest.
- Hazard: write data phase with buffer valid while a read address phase is presented and no drain is possible.
  - Insert exactly one wait state (s_hready_resp=0, s_hresp=0). The old entry drains in that cycle.
  - Next cycle s_hready_resp=1: write loads and the read is accepted.
- FSM states: IDLE, RDATA, WDATA, WWAIT, ERR1, ERR2.
- Sustained reads may hold an entry pending indefinitely; forwarding guarantees coherence.

Optional Feature:
- Macro AHB_SRAM_PARITY_EN.
- Defined: SRAM data is 36 bits, bits[35:32] hold even parity of each byte.
  - Drains write computed parity.
  - On read, a parity mismatch on any non-forwarded lane gives the two-cycle ERROR response from the data phase, with s_hrdata=0.
  - Forwarded lanes are never checked.
- Undefined: SRAM data is 32 bits with no checking.

Test Plan:
- Word write 0xDEADBEEF to BASE+0x10, then IDLE, then read 0x10 -> write drained during IDLE cycle (bwe_n=0000); read returns 0xDEADBEEF with s_hready_resp=1 throughout.
- Back-to-back write then read of same word: byte write 0xAA at 0x21 over stored 0x11223344, read 0x20 next beat -> s_hrdata=0x1122AA44 by forwarding, no wait state.
- Two writes then read (W 0x0=0x1, W 0x4=0x2, R 0x8): second write data phase with read address -> one wait cycle, SRAM write addr 0 during it; read returns prior content of 0x8.
- Access at BASE+2^(ADDR_WIDTH+2) and halfword at odd address -> hresp=01 with hready_resp 0 then 1; no ce_n activity; prior buffer still valid.
- Assert aresetn low with buffer valid -> all outputs at reset values immediately; subsequent read of that word returns old SRAM data.
- With AHB_SRAM_PARITY_EN, corrupt sram_q bit 33 on read of a non-buffered word -> two-cycle ERROR, s_hrdata=0.
